cut_bist_ctrl: RTL

Built-in self-test driver and response compactor for the sequential benchmark cores in this library, sized by default for the 18-input/19-output s832 core. It is the core's other interface end: it generates pseudo-random primary-input patterns with an LFSR, drives them into the circuit-under-test (CUT), and compacts the CUT's primary outputs into a MISR signature. At the end of a run it compares the signature against a supplied golden value and reports pass/fail.

---
 rtl/cut_bist_pkg.sv | 30 +++
 rtl/cut_bist_ctrl_step.sv | 16 +
 rtl/cut_bist_ctrl.sv | 87 ++++++++
 3 files changed

// File: rtl/cut_bist_pkg.sv
// Shared types and polynomial constants for the CUT BIST controller.
// Tap constants are polynomial exponents; the masks select the state bits that feed back.
package cut_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } bist_state_e;

  localparam int LFSR_W      = 18;
  localparam int LFSR_TAP_HI = 18;
  localparam int LFSR_TAP_LO = 11;

  localparam int MISR_W      = 19;
  localparam int MISR_TAP_A  = 19;
  localparam int MISR_TAP_B  = 6;
  localparam int MISR_TAP_C  = 2;
  localparam int MISR_TAP_D  = 1;

  // Exponent e of x^e maps to state bit e-1; the constant term is the shift-in itself.
  localparam logic [LFSR_W-1:0] LFSR_MASK =
    LFSR_W'((1 << (LFSR_TAP_HI - 1)) | (1 << (LFSR_TAP_LO - 1)));
  localparam logic [MISR_W-1:0] MISR_MASK =
    MISR_W'((1 << (MISR_TAP_A - 1)) | (1 << (MISR_TAP_B - 1)) |
            (1 << (MISR_TAP_C - 1)) | (1 << (MISR_TAP_D - 1)));

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 18'h00001;

endpackage

// File: rtl/cut_bist_ctrl_step.sv
// Combinational next-state function shared by the pattern LFSR and the response MISR.
module bist_lfsr_step #(
  parameter int           W    = 18,
  parameter logic [W-1:0] MASK = '0
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] data,
  output logic [W-1:0] nxt
);

  logic fb;

  assign fb  = ^(cur & MASK);
  assign nxt = {cur[W-2:0], fb} ^ data;

endmodule

// File: rtl/cut_bist_ctrl.sv
// BIST driver: LFSR patterns into the CUT, MISR compaction of its outputs, golden compare.
module cut_bist_ctrl
  import cut_bist_pkg::*;
#(
  parameter int              IN_W     = 18,
  parameter int              OUT_W    = 19,
  parameter int              PATTERNS = 256,
  parameter logic [IN_W-1:0] SEED     = DEFAULT_SEED
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             START,
  input  logic [OUT_W-1:0] GOLDEN_SIG,
  input  logic [OUT_W-1:0] PO_IN,
  output logic [IN_W-1:0]  PI_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic [OUT_W-1:0] SIGNATURE,
  output logic             PASS
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [IN_W-1:0] SEED_EFF = (SEED == '0) ? IN_W'(1) : SEED;
  localparam logic [15:0]     LAST_CNT = 16'(PATTERNS - 1);

  bist_state_e      state, state_nxt;
  logic [IN_W-1:0]  lfsr, lfsr_step;
  logic [OUT_W-1:0] misr, misr_step;
  logic [15:0]      cnt;
  logic             launch;
  logic             last;

  bist_lfsr_step #(.W(IN_W), .MASK(LFSR_MASK)) u_lfsr (
    .cur  (lfsr),
    .data ('0),
    .nxt  (lfsr_step)
  );

  bist_lfsr_step #(.W(OUT_W), .MASK(MISR_MASK)) u_misr (
    .cur  (misr),
    .data (PO_IN),
    .nxt  (misr_step)
  );

  assign launch = START && (state != ST_APPLY);
  assign last   = (cnt == LAST_CNT);

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (START) state_nxt = ST_APPLY;
      ST_APPLY: if (last)  state_nxt = ST_DONE;
      ST_DONE:  if (START) state_nxt = ST_APPLY;
      default:             state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      lfsr <= '0;
      misr <= '0;
      cnt  <= '0;
    end else if (launch) begin
      lfsr <= SEED_EFF;
      misr <= '0;
      cnt  <= '0;
    end else if (state == ST_APPLY) begin
      lfsr <= lfsr_step;
      misr <= misr_step;
      cnt  <= cnt + 16'd1;
    end
  end

  assign BUSY      = (state == ST_APPLY);
  assign DONE      = (state == ST_DONE);
  assign PI_OUT    = BUSY ? lfsr : '0;
  assign SIGNATURE = misr;
  assign PASS      = DONE && (misr == GOLDEN_SIG);

endmodule
